// File: rtl/cdc_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_cfg_arbiter
//
// Purpose:
//   Shares one toggle-handshake vector CDC channel among NUM_REQ configuration
//   words that live in the source clock domain. Each word is compared against a
//   shadow copy of its last acknowledged value. Changed or force-flagged words
//   are sent one at a time as {id, data} transfers under a round-robin grant.
//
// Ports:
//   clk_i        source-domain clock
//   rst_i        asynchronous, active-high reset
//   req_data_i   requester words, requester i at [i*DATA_W +: DATA_W]
//   sync_all_i   one-cycle pulse, forces a resend of every word
//   chan_rdy_i   channel can accept a word
//   chan_ack_i   one-cycle pulse, channel took the word
//   chan_wr_o    one-cycle write strobe (registered)
//   chan_id_o    id of the word being sent (registered, held until next grant)
//   chan_data_o  data of the word being sent (registered, held until next grant)
//   pending_o    per-requester pending flags (combinational)
//   busy_o       arbiter is not idle (registered)
//   timeout_o    one-cycle pulse when a transfer is abandoned for retry
//
// Optional feature:
//   CDC_ARB_TIMEOUT_EN  when defined, a WAIT that lasts TIMEOUT cycles without
//                       an ack abandons the transfer and pulses timeout_o. When
//                       undefined, WAIT waits forever and timeout_o is 0.
// -----------------------------------------------------------------------------
module cdc_cfg_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic                      sync_all_i,
    input  logic                      chan_rdy_i,
    input  logic                      chan_ack_i,
    output logic                      chan_wr_o,
    output logic [ID_W-1:0]           chan_id_o,
    output logic [DATA_W-1:0]         chan_data_o,
    output logic [NUM_REQ-1:0]        pending_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int unsigned SUM_W = ID_W + 1;

    // Elaboration-time guard on the legal parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("cdc_cfg_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   shadow_q [NUM_REQ];
    logic [NUM_REQ-1:0]  force_q;
    logic [NUM_REQ-1:0]  force_d;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     grant_id;
    logic                grant_vld;
    logic                grant_en;
    logic                ack_take;
    logic                to_hit;

    // A word is pending when it differs from its last acknowledged value or
    // has been force-flagged.
    always_comb begin
        pending_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pending_o[i] = (req_data_i[i*DATA_W +: DATA_W] != shadow_q[i]) | force_q[i];
        end
    end

    // Round-robin search: first pending index upward from last_q+1, wrapping.
    always_comb begin
        logic [SUM_W-1:0] cand;
        cand      = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!grant_vld && pending_o[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and transfer control strobes.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        ack_take = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld && chan_rdy_i) begin
                    grant_en = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (chan_ack_i) begin
                    ack_take = 1'b1;
                    state_d  = ST_IDLE;
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Force flags: an ack clears the granted bit, sync_all sets every bit and
    // wins when both happen in the same cycle.
    always_comb begin
        force_d = force_q;
        if (ack_take) begin
            force_d[chan_id_o] = 1'b0;
        end
        if (sync_all_i) begin
            force_d = '1;
        end
    end

    // Datapath: shadows, force flags, round-robin pointer and channel outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                shadow_q[i] <= '0;
            end
            force_q     <= '1;
            last_q      <= ID_W'(NUM_REQ - 1);
            chan_wr_o   <= 1'b0;
            chan_id_o   <= '0;
            chan_data_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            chan_wr_o <= (state_d == ST_SEND);
            busy_o    <= (state_d != ST_IDLE);
            force_q   <= force_d;
            if (grant_en) begin
                chan_id_o   <= grant_id;
                chan_data_o <= req_data_i[grant_id*DATA_W +: DATA_W];
            end
            // Shadow takes the latched value so a change during flight stays pending.
            if (ack_take) begin
                shadow_q[chan_id_o] <= chan_data_o;
            end
            if (ack_take || to_hit) begin
                last_q <= chan_id_o;
            end
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_q;

    // WAIT-cycle counter, cleared while in SEND so it starts at 0 in WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_SEND) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    // Last WAIT cycle of the budget with no ack: abandon; an ack here wins.
    assign to_hit = (state_q == ST_WAIT) && !chan_ack_i &&
                    (wait_cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= to_hit;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
